// File: rtl/scr1_memory_tb_ahb_pkg.sv
// Shared constants for the AHB test memory: MMIO map, AHB encodings,
// default memory size and a byte-lane helper.
package scr1_memory_tb_ahb_pkg;

    localparam int unsigned SCR1_MEM_POWER_SIZE_DEFAULT = 16;
    localparam int unsigned SCR1_IRQ_LINES_NUM          = 16;

    localparam logic [31:0] SCR1_MMIO_PRINT_ADDR   = 32'hF000_0000;
    localparam logic [31:0] SCR1_MMIO_EXT_IRQ_ADDR = 32'hF000_0100;
    localparam logic [31:0] SCR1_MMIO_SOFT_IRQ_ADDR = 32'hF000_0200;

    typedef enum logic [1:0] {
        SCR1_HTRANS_IDLE   = 2'b00,
        SCR1_HTRANS_BUSY   = 2'b01,
        SCR1_HTRANS_NONSEQ = 2'b10,
        SCR1_HTRANS_SEQ    = 2'b11
    } scr1_htrans_e;

    typedef enum logic [2:0] {
        SCR1_HSIZE_8B  = 3'b000,
        SCR1_HSIZE_16B = 3'b001,
        SCR1_HSIZE_32B = 3'b010
    } scr1_hsize_e;

    // NONSEQ and SEQ both have htrans[1] set
    function automatic logic scr1_htrans_active(input logic [1:0] htrans);
        return htrans[1];
    endfunction

    // MMIO registers are decoded on the word address
    function automatic logic scr1_mmio_hit(input logic [31:0] addr, input logic [31:0] base);
        return addr[31:2] == base[31:2];
    endfunction

    // Byte lanes written for a given transfer size and address offset;
    // sizes wider than a word are treated as a word
    function automatic logic [3:0] scr1_lane_mask(input logic [2:0] size, input logic [1:0] offs);
        logic [3:0] mask;
        case (size)
            SCR1_HSIZE_8B:  mask = 4'b0001 << offs;
            SCR1_HSIZE_16B: mask = offs[1] ? 4'b1100 : 4'b0011;
            default:        mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/scr1_memory_tb_ahb_stall_gen.sv
// HREADY stall generator: a rotating 32-bit pattern gates hready while a
// data phase is pending; an all-zero pattern disables stalling.
module scr1_tb_ahb_stall_gen
    import scr1_memory_tb_ahb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] stall_in,
    input  logic        pending,
    output logic        hready
);

    logic [31:0] pattern;

    // Pattern reloads from the input during reset, then rotates right each clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern <= stall_in;
        end else begin
            pattern <= {pattern[0], pattern[31:1]};
        end
    end

    // Ready when idle, when stalling is disabled, or when the pattern allows it
    always_comb begin
        hready = ~pending | (pattern == '0) | pattern[0];
    end

endmodule

// File: rtl/scr1_memory_tb_ahb.sv
// Dual-port AHB-Lite test memory with stall injection, a print console
// and external/software IRQ registers mapped into the data port.
module scr1_memory_tb_ahb
    import scr1_memory_tb_ahb_pkg::*;
#(
    parameter int unsigned SCR1_MEM_POWER_SIZE = SCR1_MEM_POWER_SIZE_DEFAULT
)
(
    input  logic                          clk,
    input  logic                          rst_n,
`ifdef SCR1_IPIC_EN
    output logic [SCR1_IRQ_LINES_NUM-1:0] irq_lines,
`else
    output logic                          ext_irq,
`endif
    output logic                          soft_irq,
    input  logic [31:0]                   imem_req_ack_stall_in,
    input  logic [31:0]                   dmem_req_ack_stall_in,
    input  logic [2:0]                    imem_hsize,
    input  logic [1:0]                    imem_htrans,
    input  logic [31:0]                   imem_haddr,
    output logic                          imem_hready,
    output logic [31:0]                   imem_hrdata,
    output logic                          imem_hresp,
    input  logic [2:0]                    dmem_hsize,
    input  logic [1:0]                    dmem_htrans,
    input  logic [31:0]                   dmem_haddr,
    input  logic                          dmem_hwrite,
    input  logic [31:0]                   dmem_hwdata,
    output logic                          dmem_hready,
    output logic [31:0]                   dmem_hrdata,
    output logic                          dmem_hresp
);

    localparam int unsigned MEM_SIZE = 2 ** SCR1_MEM_POWER_SIZE;
    localparam int unsigned PW       = SCR1_MEM_POWER_SIZE;
`ifdef SCR1_IPIC_EN
    localparam int unsigned IRQ_W = SCR1_IRQ_LINES_NUM;
`else
    localparam int unsigned IRQ_W = 1;
`endif

    logic [7:0]       memory [0:MEM_SIZE-1];

    logic             imem_pending;
    logic [31:2]      imem_addr_q;
    logic             dmem_pending;
    logic [31:0]      dmem_addr_q;
    logic [2:0]       dmem_size_q;
    logic             dmem_write_q;
    logic [IRQ_W-1:0] irq_q;
    logic             soft_q;

    logic             imem_accept, imem_done, imem_mmio;
    logic             dmem_accept, dmem_done, dmem_wr_done;
    logic             dmem_hit_print, dmem_hit_irq, dmem_hit_soft, mem_we;
    logic [3:0]       dmem_lanes;
    logic [31:0]      imem_word, dmem_word;
    logic             port_unused;

    // Instruction port never writes and always returns the full word
    assign port_unused = ^{imem_hsize, imem_haddr[1:0]};

    scr1_tb_ahb_stall_gen i_imem_stall (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall_in (imem_req_ack_stall_in),
        .pending  (imem_pending),
        .hready   (imem_hready)
    );

    scr1_tb_ahb_stall_gen i_dmem_stall (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall_in (dmem_req_ack_stall_in),
        .pending  (dmem_pending),
        .hready   (dmem_hready)
    );

    assign imem_hresp = 1'b0;
    assign dmem_hresp = 1'b0;

    assign imem_accept = scr1_htrans_active(imem_htrans) & imem_hready;
    assign imem_done   = imem_pending & imem_hready;
    assign dmem_accept = scr1_htrans_active(dmem_htrans) & dmem_hready;
    assign dmem_done   = dmem_pending & dmem_hready;
    assign dmem_wr_done = dmem_done & dmem_write_q;

    assign imem_mmio = scr1_mmio_hit({imem_addr_q, 2'b00}, SCR1_MMIO_PRINT_ADDR)
                     | scr1_mmio_hit({imem_addr_q, 2'b00}, SCR1_MMIO_EXT_IRQ_ADDR)
                     | scr1_mmio_hit({imem_addr_q, 2'b00}, SCR1_MMIO_SOFT_IRQ_ADDR);
    assign dmem_hit_print = scr1_mmio_hit(dmem_addr_q, SCR1_MMIO_PRINT_ADDR);
    assign dmem_hit_irq   = scr1_mmio_hit(dmem_addr_q, SCR1_MMIO_EXT_IRQ_ADDR);
    assign dmem_hit_soft  = scr1_mmio_hit(dmem_addr_q, SCR1_MMIO_SOFT_IRQ_ADDR);
    assign mem_we         = dmem_wr_done & ~(dmem_hit_print | dmem_hit_irq | dmem_hit_soft);
    assign dmem_lanes     = scr1_lane_mask(dmem_size_q, dmem_addr_q[1:0]);

    // Instruction address phase; a completing data phase may overlap a new request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_pending <= 1'b0;
            imem_addr_q  <= '0;
        end else if (imem_accept) begin
            imem_pending <= 1'b1;
            imem_addr_q  <= imem_haddr[31:2];
        end else if (imem_done) begin
            imem_pending <= 1'b0;
        end
    end

    // Data address phase, same overlap rule as the instruction port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_pending <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_size_q  <= '0;
            dmem_write_q <= 1'b0;
        end else if (dmem_accept) begin
            dmem_pending <= 1'b1;
            dmem_addr_q  <= dmem_haddr;
            dmem_size_q  <= dmem_hsize;
            dmem_write_q <= dmem_hwrite;
        end else if (dmem_done) begin
            dmem_pending <= 1'b0;
        end
    end

    // IRQ registers written through the data port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q  <= '0;
            soft_q <= 1'b0;
        end else begin
            if (dmem_wr_done && dmem_hit_irq) begin
                irq_q <= dmem_hwdata[IRQ_W-1:0];
            end
            if (dmem_wr_done && dmem_hit_soft) begin
                soft_q <= dmem_hwdata[0];
            end
        end
    end

`ifdef SCR1_IPIC_EN
    assign irq_lines = irq_q;
`else
    assign ext_irq = irq_q[0];
`endif
    assign soft_irq = soft_q;

    // Memory write at the end of the data phase; reset clears the pending flag
    // asynchronously, so an aborted transfer never reaches this point
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (dmem_lanes[i]) begin
                    memory[{dmem_addr_q[PW-1:2], 2'(i)}] <= dmem_hwdata[8*i +: 8];
                end
            end
        end
    end

`ifndef SYNTHESIS
    // Character console for software running on the bench
    always_ff @(posedge clk) begin
        if (dmem_wr_done && dmem_hit_print) begin
            $write("%c", dmem_hwdata[7:0]);
        end
    end
`endif

    // Instruction read data: aligned word, zero for MMIO and outside the data phase
    always_comb begin
        imem_word = {memory[{imem_addr_q[PW-1:2], 2'd3}], memory[{imem_addr_q[PW-1:2], 2'd2}],
                     memory[{imem_addr_q[PW-1:2], 2'd1}], memory[{imem_addr_q[PW-1:2], 2'd0}]};
        imem_hrdata = '0;
        if (imem_done && !imem_mmio) begin
            imem_hrdata = imem_word;
        end
    end

    // Data read data: MMIO registers take priority over the memory array
    always_comb begin
        dmem_word = {memory[{dmem_addr_q[PW-1:2], 2'd3}], memory[{dmem_addr_q[PW-1:2], 2'd2}],
                     memory[{dmem_addr_q[PW-1:2], 2'd1}], memory[{dmem_addr_q[PW-1:2], 2'd0}]};
        dmem_hrdata = '0;
        if (dmem_done && !dmem_write_q) begin
            if (dmem_hit_irq) begin
                dmem_hrdata = 32'(irq_q);
            end else if (dmem_hit_soft) begin
                dmem_hrdata = {31'b0, soft_q};
            end else if (!dmem_hit_print) begin
                dmem_hrdata = dmem_word;
            end
        end
    end

endmodule

// File: tb/tb_scr1_memory_tb_ahb.sv
// Self-checking bench for scr1_memory_tb_ahb: directed vector table,
// hand-written stall/reset/collision sequences and a randomized run
// against a byte-level reference memory.
module tb_scr1_memory_tb_ahb;
    import scr1_memory_tb_ahb_pkg::*;

    localparam int unsigned P   = 20;
    localparam int unsigned MEM = 1 << P;

    logic        clk;
    logic        rst_n;
    logic        soft_irq;
    logic [31:0] ext_val;
    logic [31:0] imem_req_ack_stall_in, dmem_req_ack_stall_in;
    logic [2:0]  imem_hsize, dmem_hsize;
    logic [1:0]  imem_htrans, dmem_htrans;
    logic [31:0] imem_haddr, dmem_haddr, dmem_hwdata;
    logic        dmem_hwrite;
    logic        imem_hready, imem_hresp, dmem_hready, dmem_hresp;
    logic [31:0] imem_hrdata, dmem_hrdata;
`ifdef SCR1_IPIC_EN
    logic [SCR1_IRQ_LINES_NUM-1:0] irq_lines;
    assign ext_val = 32'(irq_lines);
`else
    logic ext_irq;
    assign ext_val = {31'b0, ext_irq};
`endif

    scr1_memory_tb_ahb #(.SCR1_MEM_POWER_SIZE(P)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
`ifdef SCR1_IPIC_EN
        .irq_lines             (irq_lines),
`else
        .ext_irq               (ext_irq),
`endif
        .soft_irq              (soft_irq),
        .imem_req_ack_stall_in (imem_req_ack_stall_in),
        .dmem_req_ack_stall_in (dmem_req_ack_stall_in),
        .imem_hsize            (imem_hsize),
        .imem_htrans           (imem_htrans),
        .imem_haddr            (imem_haddr),
        .imem_hready           (imem_hready),
        .imem_hrdata           (imem_hrdata),
        .imem_hresp            (imem_hresp),
        .dmem_hsize            (dmem_hsize),
        .dmem_htrans           (dmem_htrans),
        .dmem_haddr            (dmem_haddr),
        .dmem_hwrite           (dmem_hwrite),
        .dmem_hwdata           (dmem_hwdata),
        .dmem_hready           (dmem_hready),
        .dmem_hrdata           (dmem_hrdata),
        .dmem_hresp            (dmem_hresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    // Reference memory: bytes keyed by physical address
    logic [7:0] ref_mem [int unsigned];

    function automatic void ref_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
        int unsigned nb, start, b;
        nb    = (size >= 3'd2) ? 4 : (1 << size);
        start = addr & ~(nb - 1);
        for (int unsigned k = 0; k < nb; k++) begin
            b = start + k;
            ref_mem[b % MEM] = wdata[8 * (b % 4) +: 8];
        end
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] addr);
        int unsigned base;
        base = (addr % MEM) & ~32'd3;
        return {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
    endfunction

    task automatic dmem_xfer(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                             input logic [31:0] wdata, output logic [31:0] rdata);
        bit done;
        @(negedge clk);
        dmem_htrans = SCR1_HTRANS_NONSEQ;
        dmem_haddr  = addr;
        dmem_hsize  = size;
        dmem_hwrite = wr;
        @(negedge clk);
        dmem_htrans = SCR1_HTRANS_IDLE;
        dmem_hwdata = wdata;
        done  = 1'b0;
        rdata = '0;
        for (int n = 0; n < 64 && !done; n++) begin
            if (dmem_hready) begin
                done  = 1'b1;
                rdata = dmem_hrdata;
                check32("dmem_hresp", {31'b0, dmem_hresp}, 32'd0);
            end else begin
                @(negedge clk);
            end
        end
        if (!done) check32("dmem_timeout", {31'b0, done}, 32'd1);
    endtask

    task automatic imem_read(input logic [31:0] addr, output logic [31:0] rdata);
        bit done;
        @(negedge clk);
        imem_htrans = SCR1_HTRANS_NONSEQ;
        imem_haddr  = addr;
        imem_hsize  = SCR1_HSIZE_32B;
        @(negedge clk);
        imem_htrans = SCR1_HTRANS_IDLE;
        done  = 1'b0;
        rdata = '0;
        for (int n = 0; n < 64 && !done; n++) begin
            if (imem_hready) begin
                done  = 1'b1;
                rdata = imem_hrdata;
                check32("imem_hresp", {31'b0, imem_hresp}, 32'd0);
            end else begin
                @(negedge clk);
            end
        end
        if (!done) check32("imem_timeout", {31'b0, done}, 32'd1);
    endtask

    // Reset with new stall patterns; checks the reset state while rst_n is low
    task automatic do_reset(input logic [31:0] istall, input logic [31:0] dstall);
        @(negedge clk);
        imem_htrans = SCR1_HTRANS_IDLE;
        dmem_htrans = SCR1_HTRANS_IDLE;
        imem_req_ack_stall_in = istall;
        dmem_req_ack_stall_in = dstall;
        rst_n = 1'b0;
        @(negedge clk);
        check32("rst_imem_hready", {31'b0, imem_hready}, 32'd1);
        check32("rst_dmem_hready", {31'b0, dmem_hready}, 32'd1);
        check32("rst_imem_hrdata", imem_hrdata, 32'd0);
        check32("rst_dmem_hrdata", dmem_hrdata, 32'd0);
        check32("rst_soft_irq", {31'b0, soft_irq}, 32'd0);
        check32("rst_ext_irq", ext_val, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        exp_soft;
        logic [31:0] exp_ext;
    } vec_t;

    vec_t        vecs [26];
    logic [31:0] rd;
    logic [31:0] pool [16];
    logic [31:0] a, wd;
    logic [2:0]  sz;
    logic [31:0] stall5;

    initial begin
        rst_n = 1'b0;
        imem_htrans = SCR1_HTRANS_IDLE;
        dmem_htrans = SCR1_HTRANS_IDLE;
        imem_haddr = '0; imem_hsize = '0;
        dmem_haddr = '0; dmem_hsize = '0; dmem_hwrite = 1'b0; dmem_hwdata = '0;
        imem_req_ack_stall_in = '0;
        dmem_req_ack_stall_in = '0;

        //         wr  addr           size  wdata          exp read       soft ext
        vecs[0]  = '{1, 32'h0000_0200, 3'd2, 32'h0000_0013, 32'h0,         0, 32'd0};
        vecs[1]  = '{1, 32'h0000_0300, 3'd2, 32'hA5A5_A5A5, 32'h0,         0, 32'd0};
        vecs[2]  = '{1, 32'h0000_1000, 3'd2, 32'h1122_3344, 32'h0,         0, 32'd0};
        vecs[3]  = '{1, 32'h0000_1003, 3'd0, 32'hAA00_0000, 32'h0,         0, 32'd0};
        vecs[4]  = '{0, 32'h0000_1000, 3'd2, 32'h0,         32'hAA22_3344, 0, 32'd0};
        vecs[5]  = '{1, 32'h0000_1002, 3'd1, 32'h5566_0000, 32'h0,         0, 32'd0};
        vecs[6]  = '{0, 32'h0000_1000, 3'd2, 32'h0,         32'h5566_3344, 0, 32'd0};
        vecs[7]  = '{1, 32'h0000_1000, 3'd1, 32'h0000_BEEF, 32'h0,         0, 32'd0};
        vecs[8]  = '{0, 32'h0000_1001, 3'd0, 32'h0,         32'h5566_BEEF, 0, 32'd0};
        vecs[9]  = '{1, 32'h0000_1001, 3'd0, 32'h0000_7700, 32'h0,         0, 32'd0};
        vecs[10] = '{0, 32'h0000_1000, 3'd2, 32'h0,         32'h5566_77EF, 0, 32'd0};
        vecs[11] = '{1, 32'h0000_0004, 3'd2, 32'hCAFE_F00D, 32'h0,         0, 32'd0};
        vecs[12] = '{0, 32'h0010_0004, 3'd2, 32'h0,         32'hCAFE_F00D, 0, 32'd0};
        vecs[13] = '{1, 32'h0010_0008, 3'd2, 32'h0BAD_BEEF, 32'h0,         0, 32'd0};
        vecs[14] = '{0, 32'h0000_0008, 3'd2, 32'h0,         32'h0BAD_BEEF, 0, 32'd0};
        vecs[15] = '{1, 32'h0000_0000, 3'd2, 32'h1234_5678, 32'h0,         0, 32'd0};
        vecs[16] = '{1, 32'hF000_0000, 3'd2, 32'h0000_000A, 32'h0,         0, 32'd0};
        vecs[17] = '{0, 32'h0000_0000, 3'd2, 32'h0,         32'h1234_5678, 0, 32'd0};
        vecs[18] = '{1, 32'hF000_0200, 3'd2, 32'h0000_0001, 32'h0,         1, 32'd0};
        vecs[19] = '{0, 32'hF000_0200, 3'd2, 32'h0,         32'h0000_0001, 1, 32'd0};
        vecs[20] = '{1, 32'hF000_0100, 3'd2, 32'h0000_0001, 32'h0,         1, 32'd1};
        vecs[21] = '{0, 32'hF000_0100, 3'd2, 32'h0,         32'h0000_0001, 1, 32'd1};
        vecs[22] = '{1, 32'hF000_0200, 3'd2, 32'h0000_0000, 32'h0,         0, 32'd1};
        vecs[23] = '{0, 32'hF000_0200, 3'd2, 32'h0,         32'h0000_0000, 0, 32'd1};
        vecs[24] = '{1, 32'hF000_0100, 3'd0, 32'h0000_0000, 32'h0,         0, 32'd0};
        vecs[25] = '{1, 32'h0000_0400, 3'd2, 32'h600D_F00D, 32'h0,         0, 32'd0};

        do_reset(32'h0, 32'h0000_00D3);

        // Directed vector table through the data port
        for (int i = 0; i < 26; i++) begin
            dmem_xfer(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, rd);
            if (!vecs[i].wr) check32($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
            @(negedge clk);
            check32($sformatf("vec%0d_soft_irq", i), {31'b0, soft_irq}, {31'b0, vecs[i].exp_soft});
            check32($sformatf("vec%0d_ext_irq", i), ext_val, vecs[i].exp_ext);
        end

        // Instruction fetch with no stall: data in the cycle after the address phase
        do_reset(32'h0, 32'h0);
        imem_htrans = SCR1_HTRANS_NONSEQ;
        imem_haddr  = 32'h0000_0200;
        imem_hsize  = SCR1_HSIZE_32B;
        @(negedge clk);
        imem_htrans = SCR1_HTRANS_IDLE;
        check32("fetch_hready", {31'b0, imem_hready}, 32'd1);
        check32("fetch_hrdata", imem_hrdata, 32'h0000_0013);

        // Same-word imem read and dmem write in the same data phase
        @(negedge clk);
        dmem_htrans = SCR1_HTRANS_NONSEQ; dmem_haddr = 32'h300; dmem_hsize = 3'd2; dmem_hwrite = 1'b1;
        imem_htrans = SCR1_HTRANS_NONSEQ; imem_haddr = 32'h300;
        @(negedge clk);
        dmem_htrans = SCR1_HTRANS_IDLE; imem_htrans = SCR1_HTRANS_IDLE;
        dmem_hwdata = 32'h5A5A_5A5A;
        check32("collide_hready", {31'b0, imem_hready}, 32'd1);
        check32("collide_old_data", imem_hrdata, 32'hA5A5_A5A5);
        imem_read(32'h300, rd);
        check32("collide_new_data", rd, 32'h5A5A_5A5A);

        // Instruction reads of MMIO return zero
        dmem_xfer(1'b1, 32'hF000_0200, 3'd2, 32'h1, rd);
        imem_read(32'hF000_0200, rd);
        check32("imem_mmio_zero", rd, 32'd0);

        // Stall pattern 0x5 with back-to-back fetches
        stall5 = 32'h0000_0005;
        do_reset(stall5, 32'h0);
        imem_htrans = SCR1_HTRANS_NONSEQ;
        imem_haddr  = 32'h0000_0200;
        for (int k = 0; k < 40; k++) begin
            logic exp_rdy;
            exp_rdy = (k == 0) ? 1'b1 : stall5[k % 32];
            check32($sformatf("stall_hready_k%0d", k), {31'b0, imem_hready}, {31'b0, exp_rdy});
            check32($sformatf("stall_hrdata_k%0d", k), imem_hrdata,
                    (k > 0 && exp_rdy) ? 32'h0000_0013 : 32'd0);
            @(negedge clk);
        end
        imem_htrans = SCR1_HTRANS_IDLE;

        // Reset during a stalled dmem write
        do_reset(32'h0, 32'h0);
        dmem_xfer(1'b1, 32'hF000_0200, 3'd2, 32'h1, rd);
        dmem_xfer(1'b1, 32'hF000_0100, 3'd2, 32'h1, rd);
        do_reset(32'h0, 32'h8000_0000);
        dmem_htrans = SCR1_HTRANS_NONSEQ; dmem_haddr = 32'h400; dmem_hsize = 3'd2; dmem_hwrite = 1'b1;
        dmem_hwdata = 32'hDEAD_DEAD;
        @(negedge clk);
        dmem_htrans = SCR1_HTRANS_IDLE;
        check32("abort_stalled_k1", {31'b0, dmem_hready}, 32'd0);
        @(negedge clk);
        check32("abort_stalled_k2", {31'b0, dmem_hready}, 32'd0);
        do_reset(32'h0, 32'h0);
        dmem_xfer(1'b0, 32'h400, 3'd2, 32'h0, rd);
        check32("abort_no_write", rd, 32'h600D_F00D);
        check32("abort_soft_irq", {31'b0, soft_irq}, 32'd0);
        check32("abort_ext_irq", ext_val, 32'd0);

        // Randomized traffic against the reference memory
        do_reset($urandom, $urandom);
        for (int i = 0; i < 16; i++) begin
            pool[i] = 32'h0008_0000 + 32'(i) * 32'h40;
            wd = $urandom;
            dmem_xfer(1'b1, pool[i], 3'd2, wd, rd);
            ref_write(pool[i], 3'd2, wd);
        end
        for (int i = 0; i < 200; i++) begin
            a  = pool[$urandom_range(0, 15)] + 32'($urandom_range(0, 3))
               + (32'($urandom_range(0, 3)) << 20);
            sz = 3'($urandom_range(0, 2));
            wd = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                dmem_xfer(1'b1, a, sz, wd, rd);
                ref_write(a, sz, wd);
            end else if ($urandom_range(0, 3) == 0) begin
                imem_read(a, rd);
                check32($sformatf("rand%0d_imem_%08h", i, a), rd, ref_read(a));
            end else begin
                dmem_xfer(1'b0, a, sz, 32'h0, rd);
                check32($sformatf("rand%0d_dmem_%08h", i, a), rd, ref_read(a));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
